// File: rtl/pe_buffer_pkg.sv
// Shared definitions for the PE-buffer writer and controller: FSM states and
// the segment/beat geometry helpers derived from the block parameters.
package pe_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        STREAM,
        SWITCH,
        SETTLE_W
    } pe_state_t;

    // Counter width able to hold 0..value-1; never narrower than one bit.
    function automatic int pb_log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Segments per output row.
    function automatic int pb_segs(input int hout, input int iw);
        return hout / iw;
    endfunction

    // Beats needed to cover every row FIFO of a bank once per segment.
    function automatic int pb_beats(input int ih, input int bi);
        return (ih + bi - 1) / bi;
    endfunction

endpackage

// File: rtl/pe_lane_mapper.sv
// Combinational lane decode: which write lanes land on a real row FIFO for
// the current row_base, and which FIFO each one targets.
module pe_lane_mapper
    import pe_buffer_pkg::*;
#(
    parameter int Ih          = 29,
    parameter int Bi          = 4,
    parameter int ROWID_WIDTH = 6
) (
    input  logic [ROWID_WIDTH-1:0]         row_base,
    output logic [Bi-1:0]                  lane_valid,
    output logic [Bi-1:0][ROWID_WIDTH-1:0] lane_row
);

    for (genvar gi = 0; gi < Bi; gi++) begin : g_lane
        // One extra bit so row_base+lane cannot wrap past Ih.
        logic [ROWID_WIDTH:0] row_sum;

        assign row_sum          = {1'b0, row_base} + (ROWID_WIDTH + 1)'(gi);
        assign lane_valid[gi]   = (row_sum < (ROWID_WIDTH + 1)'(Ih));
        assign lane_row[gi]     = lane_valid[gi] ? row_sum[ROWID_WIDTH-1:0] : '0;
    end

endmodule

// File: rtl/pe_buffer_writer.sv
// Streams Bi row segments per beat into the fill bank of a double-buffered
// PE row-FIFO array, then flips banks once a whole group has been written.
module pe_buffer_writer
    import pe_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int HOUT        = 56,
    parameter int Ih          = 29,
    parameter int Iw          = 7,
    parameter int Bi          = 4,
    parameter int ROWID_WIDTH = 6,
    parameter int SETTLE      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [Bi-1:0][Iw-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                   buffer_ready,
    output logic                                   pe_buffer_switch,
    output logic [Bi-1:0]                          pe_buffer_fifo_we,
    output logic [Bi-1:0][ROWID_WIDTH-1:0]         BI_rowID,
    output logic [Bi-1:0][Iw-1:0][DATA_WIDTH-1:0]  pe_buffer_input,
    output logic                                   group_done,
    output logic [15:0]                            group_cnt
);

    localparam int SEGS  = pb_segs(HOUT, Iw);
    localparam int SEG_W = pb_log2(SEGS);
    localparam int SET_W = pb_log2(SETTLE + 1);

    pe_state_t                      state_reg;
    logic [SEG_W-1:0]               seg_reg;
    logic [ROWID_WIDTH-1:0]         row_base_reg;
    logic [SET_W-1:0]               settle_cnt_reg;

    logic [Bi-1:0]                  lane_valid;
    logic [Bi-1:0][ROWID_WIDTH-1:0] lane_row;
    logic                           accept;
    logic                           last_row_beat;
    logic                           last_beat;

    assign in_ready      = (state_reg == STREAM);
    assign accept        = in_valid && in_ready;
    assign last_row_beat = (int'(row_base_reg) + Bi >= Ih);
    assign last_beat     = last_row_beat && (int'(seg_reg) == SEGS - 1);

    pe_lane_mapper #(
        .Ih          (Ih),
        .Bi          (Bi),
        .ROWID_WIDTH (ROWID_WIDTH)
    ) u_lane_mapper (
        .row_base   (row_base_reg),
        .lane_valid (lane_valid),
        .lane_row   (lane_row)
    );

    // group_done/group_cnt update on the edge that enters SWITCH, so the pulse
    // coincides with the final write; the bank flips on the edge leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            seg_reg          <= '0;
            row_base_reg     <= '0;
            settle_cnt_reg   <= '0;
            pe_buffer_switch <= 1'b0;
            group_done       <= 1'b0;
            group_cnt        <= '0;
        end else begin
            group_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (buffer_ready) begin
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (last_row_beat) begin
                            row_base_reg <= '0;
                            seg_reg      <= last_beat ? '0 : seg_reg + SEG_W'(1);
                        end else begin
                            row_base_reg <= row_base_reg + ROWID_WIDTH'(Bi);
                        end
                        if (last_beat) begin
                            state_reg  <= SWITCH;
                            group_done <= 1'b1;
                            group_cnt  <= group_cnt + 16'd1;
                        end
                    end
                end
                SWITCH: begin
                    pe_buffer_switch <= ~pe_buffer_switch;
                    settle_cnt_reg   <= '0;
                    state_reg        <= SETTLE_W;
                end
                SETTLE_W: begin
                    if (int'(settle_cnt_reg) + 1 >= SETTLE) begin
                        state_reg <= WAIT_RDY;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Write port: registered copy of the accepted beat, zero on idle lanes.
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            pe_buffer_fifo_we <= '0;
            BI_rowID          <= '0;
            pe_buffer_input   <= '0;
        end else begin
            for (int m = 0; m < Bi; m++) begin
                pe_buffer_fifo_we[m] <= lane_valid[m];
                BI_rowID[m]          <= lane_row[m];
                pe_buffer_input[m]   <= lane_valid[m] ? in_data[m] : '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_buffer_writer.sv
// Self-checking bench for pe_buffer_writer: table of group scenarios against a
// beat-index reference model, plus hand sequences for bank hold and reset.
module tb_pe_buffer_writer;

    localparam int DW      = 8;
    localparam int HOUT    = 56;
    localparam int IH      = 29;
    localparam int IW      = 7;
    localparam int BI      = 4;
    localparam int RW      = 6;
    localparam int SETTLE  = 2;
    localparam int SEGS    = HOUT / IW;
    localparam int BEATS   = (IH + BI - 1) / BI;
    localparam int GBEATS  = SEGS * BEATS;

    logic                           clk;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [BI-1:0][IW-1:0][DW-1:0]  in_data;
    logic                           buffer_ready;
    logic                           pe_buffer_switch;
    logic [BI-1:0]                  pe_buffer_fifo_we;
    logic [BI-1:0][RW-1:0]          BI_rowID;
    logic [BI-1:0][IW-1:0][DW-1:0]  pe_buffer_input;
    logic                           group_done;
    logic [15:0]                    group_cnt;

    pe_buffer_writer #(
        .DATA_WIDTH  (DW),
        .HOUT        (HOUT),
        .Ih          (IH),
        .Iw          (IW),
        .Bi          (BI),
        .ROWID_WIDTH (RW),
        .SETTLE      (SETTLE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .buffer_ready      (buffer_ready),
        .pe_buffer_switch  (pe_buffer_switch),
        .pe_buffer_fifo_we (pe_buffer_fifo_we),
        .BI_rowID          (BI_rowID),
        .pe_buffer_input   (pe_buffer_input),
        .group_done        (group_done),
        .group_cnt         (group_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beat_k = 0;
    int groups_model = 0;
    int writes_seen = 0;
    int toggle_cyc = -1;
    int hist[2][IH];

    logic [BI-1:0]                  exp_we;
    logic [BI-1:0][RW-1:0]          exp_row;
    logic [BI-1:0][IW-1:0][DW-1:0]  exp_data;
    logic                           exp_done;
    logic [15:0]                    exp_cnt;
    logic                           exp_sw;
    logic                           toggle_due;
    logic                           prev_ready;

    typedef struct {
        bit do_rst;
        int n_groups;
        int vmode;       // 0: valid every cycle, 1: every other cycle, 2: random valid/ready
        int exp_cnt;
        bit exp_sw;
        int exp_writes;
    } vec_t;

    vec_t vecs[4];

    task automatic clear_hist();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < IH; r++)
                hist[b][r] = 0;
    endtask

    // Compare the outputs produced by the previous edge with the model.
    task automatic compare_outputs();
        int bank;
        bit rows_ok;
        if (toggle_due) begin
            exp_sw     = ~exp_sw;
            toggle_due = 1'b0;
            toggle_cyc = cyc;
        end
        checks++;
        if (pe_buffer_fifo_we !== exp_we || BI_rowID !== exp_row || pe_buffer_input !== exp_data) begin
            errors++;
            $display("FAIL lanes cyc=%0d we=%b want %b row=%h want %h data=%h want %h",
                     cyc, pe_buffer_fifo_we, exp_we, BI_rowID, exp_row, pe_buffer_input, exp_data);
        end
        checks++;
        if (group_done !== exp_done || group_cnt !== exp_cnt || pe_buffer_switch !== exp_sw ||
            (exp_done && in_ready !== 1'b0)) begin
            errors++;
            $display("FAIL ctl cyc=%0d done=%b want %b cnt=%0d want %0d sw=%b want %b ready=%b",
                     cyc, group_done, exp_done, group_cnt, exp_cnt, pe_buffer_switch, exp_sw, in_ready);
        end
        bank = (pe_buffer_switch === 1'b1) ? 1 : 0;
        for (int m = 0; m < BI; m++) begin
            if (pe_buffer_fifo_we[m] === 1'b1) begin
                writes_seen++;
                if (int'(BI_rowID[m]) < IH) hist[bank][BI_rowID[m]]++;
            end
        end
        if (exp_done) begin
            rows_ok = 1'b1;
            for (int r = 0; r < IH; r++)
                if (hist[bank][r] != SEGS) rows_ok = 1'b0;
            checks++;
            if (!rows_ok) begin
                errors++;
                $display("FAIL bank_rows cyc=%0d bank=%0d row0=%0d row28=%0d want %0d each",
                         cyc, bank, hist[bank][0], hist[bank][IH-1], SEGS);
            end
            for (int r = 0; r < IH; r++) hist[bank][r] = 0;
            toggle_due = 1'b1;
        end
        if (in_ready === 1'b1 && prev_ready !== 1'b1 && toggle_cyc >= 0) begin
            checks++;
            if (cyc - toggle_cyc < SETTLE + 1) begin
                errors++;
                $display("FAIL settle_gap cyc=%0d gap=%0d want >= %0d", cyc, cyc - toggle_cyc, SETTLE + 1);
            end
            toggle_cyc = -1;
        end
        prev_ready = in_ready;
        cyc++;
    endtask

    // One clock: check last edge's outputs, drive new inputs, predict the next edge.
    task automatic cycle(input logic r, input logic v, input logic br);
        int rb;
        compare_outputs();
        rst          = r;
        in_valid     = v;
        buffer_ready = br;
        for (int b = 0; b < BI; b++)
            for (int p = 0; p < IW; p++)
                in_data[b][p] = DW'($urandom);
        exp_we   = '0;
        exp_row  = '0;
        exp_data = '0;
        exp_done = 1'b0;
        if (r) begin
            beat_k     = 0;
            exp_cnt    = '0;
            exp_sw     = 1'b0;
            toggle_due = 1'b0;
            toggle_cyc = -1;
            clear_hist();
        end else if (v && in_ready === 1'b1) begin
            rb = (beat_k % BEATS) * BI;
            for (int m = 0; m < BI; m++) begin
                if (rb + m < IH) begin
                    exp_we[m]   = 1'b1;
                    exp_row[m]  = RW'(rb + m);
                    exp_data[m] = in_data[m];
                end
            end
            beat_k++;
            if (beat_k == GBEATS) begin
                beat_k   = 0;
                exp_done = 1'b1;
                exp_cnt  = exp_cnt + 16'd1;
                groups_model++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_groups(input int n, input int vmode);
        int target;
        int budget;
        logic v;
        logic br;
        target = groups_model + n;
        budget = 0;
        while (groups_model < target && budget < 3000 * n) begin
            case (vmode)
                0:       begin v = 1'b1;            br = 1'b1; end
                1:       begin v = (cyc % 2 == 0);  br = 1'b1; end
                default: begin v = 1'($urandom);    br = 1'($urandom); end
            endcase
            cycle(1'b0, v, br);
            budget++;
        end
        checks++;
        if (groups_model < target) begin
            errors++;
            $display("FAIL group_timeout groups=%0d want %0d", groups_model, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int wait_n;

        vecs[0] = '{do_rst: 1'b0, n_groups: 1, vmode: 0, exp_cnt: 1, exp_sw: 1'b1, exp_writes: 232};
        vecs[1] = '{do_rst: 1'b0, n_groups: 1, vmode: 1, exp_cnt: 2, exp_sw: 1'b0, exp_writes: 232};
        vecs[2] = '{do_rst: 1'b1, n_groups: 3, vmode: 0, exp_cnt: 3, exp_sw: 1'b1, exp_writes: 696};
        vecs[3] = '{do_rst: 1'b0, n_groups: 1, vmode: 2, exp_cnt: 4, exp_sw: 1'b0, exp_writes: 232};

        rst = 1'b1; in_valid = 1'b0; buffer_ready = 1'b0; in_data = '0;
        exp_we = '0; exp_row = '0; exp_data = '0; exp_done = 1'b0;
        exp_cnt = '0; exp_sw = 1'b0; toggle_due = 1'b0; prev_ready = 1'b0;
        clear_hist();
        repeat (2) @(negedge clk);

        // Reset state, checked through the model's all-zero expectation.
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b want 0", in_ready);
        end

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_rst) cycle(1'b1, 1'b0, 1'b0);
            w0 = writes_seen;
            run_groups(vecs[i].n_groups, vecs[i].vmode);
            repeat (SETTLE + 4) cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (int'(group_cnt) != vecs[i].exp_cnt || pe_buffer_switch !== vecs[i].exp_sw ||
                writes_seen - w0 != vecs[i].exp_writes) begin
                errors++;
                $display("FAIL vec%0d cnt=%0d want %0d sw=%b want %b writes=%0d want %0d",
                         i, group_cnt, vecs[i].exp_cnt, pe_buffer_switch, vecs[i].exp_sw,
                         writes_seen - w0, vecs[i].exp_writes);
            end
        end

        // Receiver bank not ready: nothing may be accepted until it is raised.
        run_groups(1, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready i=%0d got=%b want 0", i, in_ready);
            end
        end
        wait_n = 0;
        while (in_ready !== 1'b1 && wait_n < 10) begin
            cycle(1'b0, 1'b0, 1'b1);
            wait_n++;
        end
        checks++;
        if (wait_n != 1) begin
            errors++;
            $display("FAIL raise_ready cycles=%0d want 1", wait_n);
        end
        run_groups(1, 1);

        // Reset after 30 beats discards the partial group.
        w0 = 0;
        while (beat_k < 30 && w0 < 200) begin
            cycle(1'b0, 1'b1, 1'b1);
            w0++;
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (pe_buffer_fifo_we !== '0 || BI_rowID !== '0 || pe_buffer_input !== '0 ||
            pe_buffer_switch !== 1'b0 || group_done !== 1'b0 || group_cnt !== 16'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset we=%b sw=%b done=%b cnt=%0d ready=%b want all 0",
                     pe_buffer_fifo_we, pe_buffer_switch, group_done, group_cnt, in_ready);
        end
        run_groups(1, 0);
        repeat (SETTLE + 4) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (group_cnt !== 16'd1 || pe_buffer_switch !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_group cnt=%0d want 1 sw=%b want 1", group_cnt, pe_buffer_switch);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
